// File: rtl/fetch_decode_execute_pkg.sv
// Shared encodings for the fetch/decode/execute front end: opcodes, conditions,
// instruction classes, CPSR flag positions and the condition evaluator.
package fetch_decode_execute_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    localparam int CPSR_N = 31;
    localparam int CPSR_Z = 30;
    localparam int CPSR_C = 29;
    localparam int CPSR_V = 28;

    typedef enum logic [2:0] {
        IT_DP   = 3'd0,
        IT_MUL  = 3'd1,
        IT_MLA  = 3'd2,
        IT_MULL = 3'd3,
        IT_MLAL = 3'd4
    } instr_t;

    function automatic logic cond_pass(input logic [3:0] cond, input logic n,
                                       input logic z, input logic c, input logic v);
        logic pass;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/fetch_decode_execute_alu.sv
// 16-opcode data-processing ALU with adder carry (NOT-borrow) and signed overflow.
// Purely combinational, no flow control.
module fetch_decode_execute_alu
    import fetch_decode_execute_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  opcode,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        carry_out,
    output logic        overflow,
    output logic        arith
);

    logic [31:0] x;
    logic [31:0] y;
    logic        ci;
    logic [32:0] sum;

    always_comb begin
        x     = a;
        y     = b;
        ci    = 1'b0;
        arith = 1'b1;
        case (opcode)
            OP_SUB, OP_CMP: begin y = ~b; ci = 1'b1; end
            OP_RSB:         begin x = b; y = ~a; ci = 1'b1; end
            OP_ADD, OP_CMN: begin ci = 1'b0; end
            OP_ADC:         begin ci = carry_in; end
            OP_SBC:         begin y = ~b; ci = carry_in; end
            OP_RSC:         begin x = b; y = ~a; ci = carry_in; end
            default:        begin arith = 1'b0; end
        endcase

        sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};

        case (opcode)
            OP_AND, OP_TST: result = a & b;
            OP_EOR, OP_TEQ: result = a ^ b;
            OP_ORR:         result = a | b;
            OP_MOV:         result = b;
            OP_BIC:         result = a & ~b;
            OP_MVN:         result = ~b;
            default:        result = sum[31:0];
        endcase

        carry_out = sum[32];
        overflow  = (x[31] == y[31]) && (sum[31] != x[31]);
    end

endmodule

// File: rtl/fetch_decode_execute_barrel_shifter.sv
// Operand2 generator: rotated immediate or shifted register plus shifter carry-out.
// Purely combinational, no flow control.
module fetch_decode_execute_barrel_shifter
    import fetch_decode_execute_pkg::*;
(
    input  logic        imm,
    input  logic [7:0]  imm8,
    input  logic [3:0]  rot,
    input  logic [31:0] rm,
    input  logic [1:0]  shift_type,
    input  logic        shift_reg,
    input  logic [4:0]  shift_imm,
    input  logic [7:0]  rs_lo,
    input  logic        carry_in,
    output logic [31:0] op2,
    output logic        carry_out
);

    logic [8:0]  amt;
    logic [5:0]  clamp;
    logic [63:0] wide;

    always_comb begin
        op2       = rm;
        carry_out = carry_in;
        amt       = '0;
        clamp     = '0;
        wide      = '0;
        if (imm) begin
            wide      = {24'd0, imm8, 24'd0, imm8} >> {rot, 1'b0};
            op2       = wide[31:0];
            carry_out = (rot != 4'd0) ? wide[31] : carry_in;
        end else begin
            if (shift_reg)
                amt = {1'b0, rs_lo};
            else if (shift_imm == 5'd0 && (shift_type == SH_LSR || shift_type == SH_ASR))
                amt = 9'd32;
            else
                amt = {4'd0, shift_imm};
            clamp = (amt > 9'd32) ? 6'd32 : amt[5:0];

            // A 64-bit window keeps the last bit shifted out next to the result.
            if (!shift_reg && shift_imm == 5'd0 && shift_type == SH_ROR) begin
                op2       = {carry_in, rm[31:1]};
                carry_out = rm[0];
            end else if (amt != 9'd0) begin
                case (shift_type)
                    SH_LSL: begin
                        wide      = {32'd0, rm} << clamp;
                        op2       = wide[31:0];
                        carry_out = (amt > 9'd32) ? 1'b0 : wide[32];
                    end
                    SH_LSR: begin
                        wide      = {rm, 32'd0} >> clamp;
                        op2       = wide[63:32];
                        carry_out = (amt > 9'd32) ? 1'b0 : wide[31];
                    end
                    SH_ASR: begin
                        wide      = $signed({rm, 32'd0}) >>> clamp;
                        op2       = wide[63:32];
                        carry_out = wide[31];
                    end
                    default: begin
                        wide      = {rm, rm} >> amt[4:0];
                        op2       = wide[31:0];
                        carry_out = wide[31];
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/fetch_decode_execute.sv
// IF/ID/EX front end: results registered 2 cycles after the instruction register loads.
// No stall or backpressure; hazards are resolved by software scheduling.
module fetch_decode_execute
    import fetch_decode_execute_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] addr,
    input  logic [31:0] rdata,
    input  logic        data_valid,
    output logic        write,
    output logic [1:0]  trans,
    input  logic        write_pc_i,
    input  logic [31:0] pc_i,
    output logic [5:0]  rr1_idx,
    output logic [5:0]  rr2_idx,
    output logic [5:0]  rr3_idx,
    output logic [5:0]  rr4_idx,
    input  logic [31:0] rr1_data,
    input  logic [31:0] rr2_data,
    input  logic [31:0] rr3_data,
    input  logic [31:0] rr4_data,
    input  logic [31:0] cpsr_i,
    output logic [3:0]  dest_o,
    output logic [3:0]  dest_hi_o,
    output logic        write_dest_do_o,
    output logic        write_dest_m_o,
    output logic        write_cpsr_o,
    output logic [31:0] cpsr_o,
    output logic [31:0] result_o,
    output logic [63:0] m_result_o
);

    logic [31:0] pc;
    logic [31:0] ir;
    logic        ir_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            ir       <= '0;
            ir_valid <= 1'b0;
        end else begin
            pc       <= write_pc_i ? pc_i : pc + 32'd4;
            ir_valid <= data_valid;
            if (data_valid)
                ir <= rdata;
        end
    end

    assign addr  = pc;
    assign write = 1'b0;
    assign trans = rst ? 2'b00 : 2'b10;

    logic is_mul;
    logic is_mull;
    logic is_dp;

    assign is_mul  = (ir[27:22] == 6'b000000) && (ir[7:4] == 4'b1001);
    assign is_mull = (ir[27:23] == 5'b00001) && (ir[7:4] == 4'b1001);
    assign is_dp   = (ir[27:26] == 2'b00) && !is_mul && !is_mull;

    // Rn sits in [19:16] for data-processing but [15:12] (Rn / RdLo) for multiplies.
    assign rr1_idx = {2'b00, is_dp ? ir[19:16] : ir[15:12]};
    assign rr2_idx = {2'b00, ir[3:0]};
    assign rr3_idx = {2'b00, ir[11:8]};
    assign rr4_idx = {2'b00, ir[19:16]};

    logic        d_exec;
    instr_t      d_type;
    logic [3:0]  d_opcode;
    logic        d_s;
    logic        d_imm;
    logic [7:0]  d_imm8;
    logic [3:0]  d_rot;
    logic [1:0]  d_sh_type;
    logic        d_sh_reg;
    logic [4:0]  d_sh_imm;
    logic        d_signed;
    logic [3:0]  d_dest;
    logic [3:0]  d_dest_hi;
    logic [31:0] d_rn;
    logic [31:0] d_rm;
    logic [31:0] d_rs;
    logic [31:0] d_rdhi;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_exec    <= 1'b0;
            d_type    <= IT_DP;
            d_opcode  <= '0;
            d_s       <= 1'b0;
            d_imm     <= 1'b0;
            d_imm8    <= '0;
            d_rot     <= '0;
            d_sh_type <= '0;
            d_sh_reg  <= 1'b0;
            d_sh_imm  <= '0;
            d_signed  <= 1'b0;
            d_dest    <= '0;
            d_dest_hi <= '0;
            d_rn      <= '0;
            d_rm      <= '0;
            d_rs      <= '0;
            d_rdhi    <= '0;
        end else begin
            d_exec    <= ir_valid && (is_dp || is_mul || is_mull) &&
                         cond_pass(ir[31:28], cpsr_i[CPSR_N], cpsr_i[CPSR_Z],
                                   cpsr_i[CPSR_C], cpsr_i[CPSR_V]);
            d_type    <= is_mull ? (ir[21] ? IT_MLAL : IT_MULL) :
                         is_mul  ? (ir[21] ? IT_MLA  : IT_MUL)  : IT_DP;
            d_opcode  <= ir[24:21];
            d_s       <= ir[20];
            d_imm     <= ir[25];
            d_imm8    <= ir[7:0];
            d_rot     <= ir[11:8];
            d_sh_type <= ir[6:5];
            d_sh_reg  <= ir[4];
            d_sh_imm  <= ir[11:7];
            d_signed  <= ir[22];
            d_dest    <= is_mul ? ir[19:16] : ir[15:12];
            d_dest_hi <= ir[19:16];
            d_rn      <= rr1_data;
            d_rm      <= rr2_data;
            d_rs      <= rr3_data;
            d_rdhi    <= rr4_data;
        end
    end

    logic [31:0] op2;
    logic        sh_carry;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic        alu_overflow;
    logic        alu_arith;

    fetch_decode_execute_barrel_shifter u_shifter (
        .imm        (d_imm),
        .imm8       (d_imm8),
        .rot        (d_rot),
        .rm         (d_rm),
        .shift_type (d_sh_type),
        .shift_reg  (d_sh_reg),
        .shift_imm  (d_sh_imm),
        .rs_lo      (d_rs[7:0]),
        .carry_in   (cpsr_i[CPSR_C]),
        .op2        (op2),
        .carry_out  (sh_carry)
    );

    fetch_decode_execute_alu u_alu (
        .a         (d_rn),
        .b         (op2),
        .opcode    (d_opcode),
        .carry_in  (cpsr_i[CPSR_C]),
        .result    (alu_result),
        .carry_out (alu_carry),
        .overflow  (alu_overflow),
        .arith     (alu_arith)
    );

    logic [63:0] ext_rm;
    logic [63:0] ext_rs;
    logic [63:0] prod;
    logic [31:0] mul32;
    logic [63:0] mull;
    logic [31:0] ex_result;
    logic [3:0]  ex_flags;
    logic        ex_wr_do;
    logic        ex_wr_m;
    logic        ex_wr_cpsr;
    logic        ex_is_test;

    always_comb begin
        // The low 64 bits of a 64x64 product of extended operands are exact for both signs.
        ext_rm     = d_signed ? {{32{d_rm[31]}}, d_rm} : {32'd0, d_rm};
        ext_rs     = d_signed ? {{32{d_rs[31]}}, d_rs} : {32'd0, d_rs};
        prod       = ext_rm * ext_rs;
        mul32      = prod[31:0] + ((d_type == IT_MLA) ? d_rn : 32'd0);
        mull       = prod + ((d_type == IT_MLAL) ? {d_rdhi, d_rn} : 64'd0);
        ex_is_test = (d_opcode[3:2] == 2'b10);
        ex_result  = alu_result;
        ex_flags   = cpsr_i[31:28];
        ex_wr_do   = 1'b0;
        ex_wr_m    = 1'b0;
        ex_wr_cpsr = d_s;
        case (d_type)
            IT_DP: begin
                ex_wr_do    = !ex_is_test;
                ex_wr_cpsr  = d_s || ex_is_test;
                ex_flags[3] = alu_result[31];
                ex_flags[2] = (alu_result == 32'd0);
                ex_flags[1] = alu_arith ? alu_carry : sh_carry;
                ex_flags[0] = alu_arith ? alu_overflow : cpsr_i[CPSR_V];
            end
            IT_MUL, IT_MLA: begin
                ex_result   = mul32;
                ex_wr_do    = 1'b1;
                ex_flags[3] = mul32[31];
                ex_flags[2] = (mul32 == 32'd0);
            end
            default: begin
                ex_wr_m     = 1'b1;
                ex_flags[3] = mull[63];
                ex_flags[2] = (mull == 64'd0);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dest_o          <= '0;
            dest_hi_o       <= '0;
            write_dest_do_o <= 1'b0;
            write_dest_m_o  <= 1'b0;
            write_cpsr_o    <= 1'b0;
            cpsr_o          <= '0;
            result_o        <= '0;
            m_result_o      <= '0;
        end else begin
            write_dest_do_o <= d_exec && ex_wr_do;
            write_dest_m_o  <= d_exec && ex_wr_m;
            write_cpsr_o    <= d_exec && ex_wr_cpsr;
            if (d_exec) begin
                dest_o    <= d_dest;
                dest_hi_o <= d_dest_hi;
                if (ex_wr_m)
                    m_result_o <= mull;
                else
                    result_o <= ex_result;
                if (ex_wr_cpsr)
                    cpsr_o <= {ex_flags, cpsr_i[27:0]};
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Directed bench for fetch_decode_execute: hand-computed vectors per feature.
module tb_fetch_decode_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        data_valid;
    logic        write;
    logic [1:0]  trans;
    logic        write_pc_i;
    logic [31:0] pc_i;
    logic [5:0]  rr1_idx, rr2_idx, rr3_idx, rr4_idx;
    logic [31:0] rr1_data, rr2_data, rr3_data, rr4_data;
    logic [31:0] cpsr_i;
    logic [3:0]  dest_o, dest_hi_o;
    logic        write_dest_do_o, write_dest_m_o, write_cpsr_o;
    logic [31:0] cpsr_o, result_o;
    logic [63:0] m_result_o;

    logic [31:0] regs [64];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        rr1_data = regs[rr1_idx];
        rr2_data = regs[rr2_idx];
        rr3_data = regs[rr3_idx];
        rr4_data = regs[rr4_idx];
    end

    fetch_decode_execute #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rdata(rdata), .data_valid(data_valid),
        .write(write), .trans(trans), .write_pc_i(write_pc_i), .pc_i(pc_i),
        .rr1_idx(rr1_idx), .rr2_idx(rr2_idx), .rr3_idx(rr3_idx), .rr4_idx(rr4_idx),
        .rr1_data(rr1_data), .rr2_data(rr2_data), .rr3_data(rr3_data), .rr4_data(rr4_data),
        .cpsr_i(cpsr_i), .dest_o(dest_o), .dest_hi_o(dest_hi_o),
        .write_dest_do_o(write_dest_do_o), .write_dest_m_o(write_dest_m_o),
        .write_cpsr_o(write_cpsr_o), .cpsr_o(cpsr_o), .result_o(result_o),
        .m_result_o(m_result_o)
    );

    // One instruction in, sampled on the negedge after its execute edge.
    task automatic issue(input logic [31:0] instr);
        @(negedge clk); rdata = instr; data_valid = 1'b1;
        @(negedge clk); data_valid = 1'b0; rdata = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", addr, 32'h0); end
        checks++; if (trans !== 2'b00) begin failures++; $display("FAIL reset_trans got=%b exp=00", trans); end
        checks++; if (write !== 1'b0) begin failures++; $display("FAIL reset_write got=%b exp=0", write); end
        checks++; if ({write_dest_do_o, write_dest_m_o, write_cpsr_o} !== 3'b000) begin failures++; $display("FAIL reset_we got=%b exp=000", {write_dest_do_o, write_dest_m_o, write_cpsr_o}); end
        checks++; if (result_o !== 32'h0 || m_result_o !== 64'h0 || cpsr_o !== 32'h0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", result_o, m_result_o, cpsr_o); end
    endtask

    task automatic test_fetch();
        rst = 1'b0;
        #1;
        checks++; if (trans !== 2'b10) begin failures++; $display("FAIL fetch_trans got=%b exp=10", trans); end
        checks++; if (addr !== 32'h0) begin failures++; $display("FAIL fetch_addr0 got=%h exp=%h", addr, 32'h0); end
        @(negedge clk);
        checks++; if (addr !== 32'h4) begin failures++; $display("FAIL fetch_addr4 got=%h exp=%h", addr, 32'h4); end
        @(negedge clk);
        checks++; if (addr !== 32'h8) begin failures++; $display("FAIL fetch_addr8 got=%h exp=%h", addr, 32'h8); end
        checks++; if (write_dest_do_o !== 1'b0) begin failures++; $display("FAIL fetch_idle_we got=%b exp=0", write_dest_do_o); end
    endtask

    task automatic test_mov_imm();
        cpsr_i = 32'h0;
        issue(32'hE3A004FF);
        checks++; if (result_o !== 32'hFF000000) begin failures++; $display("FAIL mov_result got=%h exp=%h", result_o, 32'hFF000000); end
        checks++; if (dest_o !== 4'd0 || write_dest_do_o !== 1'b1 || write_cpsr_o !== 1'b0) begin failures++; $display("FAIL mov_ctl got=%h/%b/%b exp=0/1/0", dest_o, write_dest_do_o, write_cpsr_o); end
    endtask

    task automatic test_subs();
        regs[1] = 32'd5;
        issue(32'hE0513001);
        checks++; if (result_o !== 32'h0 || dest_o !== 4'd3) begin failures++; $display("FAIL subs_result got=%h/%h exp=0/3", result_o, dest_o); end
        checks++; if (cpsr_o !== 32'h6000_0000 || write_cpsr_o !== 1'b1) begin failures++; $display("FAIL subs_flags got=%h/%b exp=60000000/1", cpsr_o, write_cpsr_o); end
    endtask

    task automatic test_cmp();
        regs[7] = 32'h7FFF_FFFF;
        issue(32'hE1510007);
        checks++; if (write_dest_do_o !== 1'b0 || write_cpsr_o !== 1'b1) begin failures++; $display("FAIL cmp_we got=%b/%b exp=0/1", write_dest_do_o, write_cpsr_o); end
        checks++; if (cpsr_o !== 32'h8000_0000) begin failures++; $display("FAIL cmp_flags got=%h exp=%h", cpsr_o, 32'h8000_0000); end
    endtask

    task automatic test_adds_overflow();
        issue(32'hE2978001);
        checks++; if (result_o !== 32'h8000_0000 || dest_o !== 4'd8) begin failures++; $display("FAIL adds_result got=%h/%h exp=80000000/8", result_o, dest_o); end
        checks++; if (cpsr_o !== 32'h9000_0000) begin failures++; $display("FAIL adds_flags got=%h exp=%h", cpsr_o, 32'h9000_0000); end
    endtask

    task automatic test_cond();
        cpsr_i = 32'h0;
        issue(32'h03A00001);
        checks++; if ({write_dest_do_o, write_dest_m_o, write_cpsr_o} !== 3'b000) begin failures++; $display("FAIL cond_ne_we got=%b exp=000", {write_dest_do_o, write_dest_m_o, write_cpsr_o}); end
        checks++; if (result_o !== 32'h8000_0000) begin failures++; $display("FAIL cond_ne_hold got=%h exp=%h", result_o, 32'h8000_0000); end
        cpsr_i = 32'h4000_0000;
        issue(32'h03A00001);
        checks++; if (result_o !== 32'h1 || write_dest_do_o !== 1'b1 || dest_o !== 4'd0) begin failures++; $display("FAIL cond_eq got=%h/%b/%h exp=1/1/0", result_o, write_dest_do_o, dest_o); end
    endtask

    task automatic test_shift();
        regs[1] = 32'hFFFF_FFFF;
        cpsr_i  = 32'h1000_00D3;
        issue(32'hE1B090A1);
        checks++; if (result_o !== 32'h7FFF_FFFF || dest_o !== 4'd9) begin failures++; $display("FAIL lsr1_result got=%h/%h exp=7fffffff/9", result_o, dest_o); end
        checks++; if (cpsr_o !== 32'h3000_00D3) begin failures++; $display("FAIL lsr1_flags got=%h exp=%h", cpsr_o, 32'h3000_00D3); end
        issue(32'hE1B0A021);
        checks++; if (result_o !== 32'h0 || cpsr_o !== 32'h7000_00D3) begin failures++; $display("FAIL lsr32 got=%h/%h exp=0/700000d3", result_o, cpsr_o); end
    endtask

    task automatic test_mul();
        regs[2] = 32'd2;
        cpsr_i  = 32'h0;
        issue(32'hE0040291);
        checks++; if (result_o !== 32'hFFFF_FFFE || dest_o !== 4'd4) begin failures++; $display("FAIL mul_result got=%h/%h exp=fffffffe/4", result_o, dest_o); end
        checks++; if (write_dest_do_o !== 1'b1 || write_dest_m_o !== 1'b0) begin failures++; $display("FAIL mul_we got=%b/%b exp=1/0", write_dest_do_o, write_dest_m_o); end
    endtask

    task automatic test_long_mul();
        issue(32'hE0865291);
        checks++; if (m_result_o !== 64'h0000_0001_FFFF_FFFE) begin failures++; $display("FAIL umull_result got=%h exp=%h", m_result_o, 64'h0000_0001_FFFF_FFFE); end
        checks++; if (dest_o !== 4'd5 || dest_hi_o !== 4'd6) begin failures++; $display("FAIL umull_dest got=%h/%h exp=5/6", dest_o, dest_hi_o); end
        checks++; if (write_dest_m_o !== 1'b1 || write_dest_do_o !== 1'b0) begin failures++; $display("FAIL umull_we got=%b/%b exp=1/0", write_dest_m_o, write_dest_do_o); end
        issue(32'hE0C65291);
        checks++; if (m_result_o !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL smull_result got=%h exp=%h", m_result_o, 64'hFFFF_FFFF_FFFF_FFFE); end
    endtask

    task automatic test_redirect();
        @(negedge clk); write_pc_i = 1'b1; pc_i = 32'h100;
        @(negedge clk); write_pc_i = 1'b0;
        checks++; if (addr !== 32'h100) begin failures++; $display("FAIL redirect_addr got=%h exp=%h", addr, 32'h100); end
        @(negedge clk);
        checks++; if (addr !== 32'h104) begin failures++; $display("FAIL redirect_next got=%h exp=%h", addr, 32'h104); end
    endtask

    task automatic test_mid_reset();
        cpsr_i = 32'h0;
        @(negedge clk); rdata = 32'hE3A00001; data_valid = 1'b1;
        @(negedge clk); data_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++; if (result_o !== 32'h0 || m_result_o !== 64'h0 || cpsr_o !== 32'h0) begin failures++; $display("FAIL midrst_data got=%h/%h/%h exp=0", result_o, m_result_o, cpsr_o); end
        checks++; if (addr !== 32'h0 || trans !== 2'b00 || dest_o !== 4'd0 || dest_hi_o !== 4'd0) begin failures++; $display("FAIL midrst_ctl got=%h/%b/%h/%h exp=0", addr, trans, dest_o, dest_hi_o); end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (write_dest_do_o !== 1'b0 || result_o !== 32'h0) begin failures++; $display("FAIL midrst_flush got=%b/%h exp=0/0", write_dest_do_o, result_o); end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) regs[i] = 32'h0;
        rst = 1'b1; rdata = '0; data_valid = 1'b0;
        write_pc_i = 1'b0; pc_i = '0; cpsr_i = '0;
        test_reset();
        test_fetch();
        test_mov_imm();
        test_subs();
        test_cmp();
        test_adds_overflow();
        test_cond();
        test_shift();
        test_mul();
        test_long_mul();
        test_redirect();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
